// File: rtl/i2c_transfer_sequencer_if.sv
// Sequencer <-> TX FIFO, RX FIFO and byte engine bundle.
// master: sequencer side; slave: FIFO/engine side.
interface i2c_transfer_sequencer_if;
  logic        TX_EMPTY;
  logic [31:0] TX_DATA;
  logic        TX_RD_EN;
  logic        RX_FULL;
  logic        RX_WR_EN;
  logic [31:0] RX_WDATA;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [7:0]  CMD_DATA;
  logic        CMD_LAST;
  logic        DONE_VALID;
  logic        DONE_NACK;
  logic [7:0]  DONE_DATA;

  modport master (
    input  TX_EMPTY, TX_DATA, RX_FULL, CMD_READY,
    input  DONE_VALID, DONE_NACK, DONE_DATA,
    output TX_RD_EN, RX_WR_EN, RX_WDATA,
    output CMD_VALID, CMD_TYPE, CMD_DATA, CMD_LAST
  );

  modport slave (
    output TX_EMPTY, TX_DATA, RX_FULL, CMD_READY,
    output DONE_VALID, DONE_NACK, DONE_DATA,
    input  TX_RD_EN, RX_WR_EN, RX_WDATA,
    input  CMD_VALID, CMD_TYPE, CMD_DATA, CMD_LAST
  );
endinterface

// File: rtl/i2c_transfer_sequencer.sv
// I2C transfer sequencer: turns a CONFIG start into ADDR/WRITE/READ/STOP
// commands. Ports: PCLK, PRESETn, CONFIG, TIMEOUT, BUSY, ERROR, XFER_DONE, bus.
module i2c_transfer_sequencer (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [13:0] CONFIG,
  input  logic [13:0] TIMEOUT,
  output logic        BUSY,
  output logic        ERROR,
  output logic        XFER_DONE,
  i2c_transfer_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, WAIT_ADDR, FETCH, WR, WAIT_WR,
    RD, WAIT_RD, PUSH, STOP, WAIT_STOP
  } state_t;

  state_t      state;
  logic        dir;
  logic [6:0]  addr;
  logic [5:0]  remain;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_byte;
  logic [13:0] stall;
  logic        cfg0_q;
  logic        armed;
  logic        start;
  logic        tmo;
  logic        unused_tx;

  assign unused_tx = ^bus.TX_DATA[31:8];

  // armed blocks a start until CONFIG[0] has been seen low after reset
  assign start = CONFIG[0] & ~cfg0_q & armed;
  assign tmo   = (TIMEOUT != '0) && (stall == TIMEOUT) && (state != IDLE);

  always_comb begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_TYPE  = 2'b00;
    bus.CMD_DATA  = 8'h00;
    bus.CMD_LAST  = 1'b0;
    unique case (state)
      ADDR: begin
        bus.CMD_VALID = 1'b1;
        bus.CMD_DATA  = {addr, dir};
      end
      WR: begin
        bus.CMD_VALID = 1'b1;
        bus.CMD_TYPE  = 2'b01;
        bus.CMD_DATA  = tx_byte;
      end
      RD: begin
        bus.CMD_VALID = 1'b1;
        bus.CMD_TYPE  = 2'b10;
        bus.CMD_LAST  = (remain == 6'd1);
      end
      STOP: begin
        bus.CMD_VALID = 1'b1;
        bus.CMD_TYPE  = 2'b11;
      end
      default: ;
    endcase
  end

  // strobes gated by tmo so a timeout never loses a popped/pushed byte
  assign bus.TX_RD_EN = (state == FETCH) & ~bus.TX_EMPTY & ~tmo;
  assign bus.RX_WR_EN = (state == PUSH) & ~bus.RX_FULL & ~tmo;
  assign bus.RX_WDATA = {24'd0, rx_byte};
  assign BUSY         = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      dir       <= 1'b0;
      addr      <= '0;
      remain    <= '0;
      tx_byte   <= '0;
      rx_byte   <= '0;
      stall     <= '0;
      cfg0_q    <= 1'b0;
      armed     <= 1'b0;
      ERROR     <= 1'b0;
      XFER_DONE <= 1'b0;
    end else begin
      cfg0_q    <= CONFIG[0];
      XFER_DONE <= 1'b0;
      if (!CONFIG[0]) armed <= 1'b1;
      stall <= (state == IDLE) ? '0 : stall + 14'd1;
      if (tmo) begin
        ERROR <= 1'b1;
        stall <= '0;
        if (state == STOP || state == WAIT_STOP) begin
          state     <= IDLE;
          XFER_DONE <= 1'b1;
        end else begin
          state <= STOP;
        end
      end else begin
        unique case (state)
          IDLE: if (start) begin
            dir    <= CONFIG[1];
            addr   <= CONFIG[8:2];
            remain <= {CONFIG[13:9] == 5'd0, CONFIG[13:9]};
            ERROR  <= 1'b0;
            state  <= ADDR;
          end
          ADDR: if (bus.CMD_READY) begin
            state <= WAIT_ADDR;
            stall <= '0;
          end
          WAIT_ADDR: if (bus.DONE_VALID) begin
            stall <= '0;
            if (bus.DONE_NACK) begin
              ERROR <= 1'b1;
              state <= STOP;
            end else begin
              state <= dir ? RD : FETCH;
            end
          end
          FETCH: if (!bus.TX_EMPTY) begin
            tx_byte <= bus.TX_DATA[7:0];
            state   <= WR;
            stall   <= '0;
          end
          WR: if (bus.CMD_READY) begin
            state <= WAIT_WR;
            stall <= '0;
          end
          WAIT_WR: if (bus.DONE_VALID) begin
            stall <= '0;
            if (bus.DONE_NACK) begin
              ERROR <= 1'b1;
              state <= STOP;
            end else begin
              remain <= remain - 6'd1;
              state  <= (remain == 6'd1) ? STOP : FETCH;
            end
          end
          RD: if (bus.CMD_READY) begin
            state <= WAIT_RD;
            stall <= '0;
          end
          WAIT_RD: if (bus.DONE_VALID) begin
            rx_byte <= bus.DONE_DATA;
            state   <= PUSH;
            stall   <= '0;
          end
          PUSH: if (!bus.RX_FULL) begin
            remain <= remain - 6'd1;
            state  <= (remain == 6'd1) ? STOP : RD;
            stall  <= '0;
          end
          STOP: if (bus.CMD_READY) begin
            state <= WAIT_STOP;
            stall <= '0;
          end
          WAIT_STOP: if (bus.DONE_VALID) begin
            state     <= IDLE;
            XFER_DONE <= 1'b1;
            stall     <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
// Scoreboard bench for i2c_transfer_sequencer: FIFO and byte engine models,
// expected commands / RX words queued at stimulus time, popped at output.
module tb_i2c_transfer_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [13:0] CONFIG;
  logic [13:0] TIMEOUT;
  logic        BUSY;
  logic        ERROR;
  logic        XFER_DONE;

  i2c_transfer_sequencer_if bus ();

  i2c_transfer_sequencer dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .CONFIG    (CONFIG),
    .TIMEOUT   (TIMEOUT),
    .BUSY      (BUSY),
    .ERROR     (ERROR),
    .XFER_DONE (XFER_DONE),
    .bus       (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [1:0] t, input logic l,
                                     input logic [7:0] d);
    return {t, l, d};
  endfunction

  logic [10:0] exp_cmd[$];
  logic [31:0] exp_rx[$];
  logic [31:0] tx_q[$];
  logic [7:0]  rd_q[$];

  bit   nack_addr = 1'b0;
  bit   hold_wr = 1'b0;
  bit   done_pend = 1'b0;
  logic [1:0] pend_type = 2'b00;
  logic pend_nack = 1'b0;
  logic [7:0] pend_data = 8'h00;

  int cmd_cnt = 0;
  int tx_pops = 0;
  int tx_seen = 0;
  int rx_pushes = 0;
  int xfer_cnt = 0;
  int addr_stall = 0;

  // TX FIFO: pop after the edge the DUT captured the head word on
  always @(posedge PCLK) begin
    #1;
    if (tx_seen != tx_pops && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_seen <= tx_pops;
    bus.TX_EMPTY <= (tx_q.size() == 0);
    bus.TX_DATA  <= (tx_q.size() > 0) ? tx_q[0] : 32'h0;
  end

  // byte engine + output monitor
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      done_pend      <= 1'b0;
      bus.DONE_VALID <= 1'b0;
      bus.DONE_NACK  <= 1'b0;
      bus.DONE_DATA  <= 8'h00;
    end else begin
      if (done_pend && !(hold_wr && pend_type == 2'b01)) begin
        bus.DONE_VALID <= 1'b1;
        bus.DONE_NACK  <= pend_nack;
        bus.DONE_DATA  <= pend_data;
        done_pend      <= 1'b0;
      end else begin
        bus.DONE_VALID <= 1'b0;
      end
      if (bus.CMD_VALID && bus.CMD_READY) begin
        cmd_cnt   <= cmd_cnt + 1;
        done_pend <= 1'b1;
        pend_type <= bus.CMD_TYPE;
        pend_nack <= (bus.CMD_TYPE == 2'b00) && nack_addr;
        pend_data <= 8'h00;
        if (bus.CMD_TYPE == 2'b10 && rd_q.size() > 0)
          pend_data <= rd_q.pop_front();
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", 32'd1, 32'd0);
        end else begin
          chk("cmd_type", bus.CMD_TYPE, exp_cmd[0][10:9]);
          chk("cmd_last", bus.CMD_LAST, exp_cmd[0][8]);
          if (!bus.CMD_TYPE[1])
            chk("cmd_data", bus.CMD_DATA, exp_cmd[0][7:0]);
          void'(exp_cmd.pop_front());
        end
      end
      if (bus.CMD_VALID && !bus.CMD_READY && bus.CMD_TYPE == 2'b00)
        addr_stall <= addr_stall + 1;
    end
    if (bus.TX_RD_EN) begin
      chk("tx_rd_while_empty", bus.TX_EMPTY, 0);
      tx_pops <= tx_pops + 1;
    end
    if (bus.RX_WR_EN) begin
      chk("rx_wr_while_full", bus.RX_FULL, 0);
      rx_pushes <= rx_pushes + 1;
      if (exp_rx.size() == 0) begin
        chk("rx_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rx_data", bus.RX_WDATA, exp_rx[0]);
        void'(exp_rx.pop_front());
      end
    end
    if (XFER_DONE) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic start_xfer(input logic dir, input logic [6:0] a,
                            input logic [4:0] cnt);
    @(negedge PCLK);
    CONFIG = {cnt, a, dir, 1'b0};
    @(negedge PCLK);
    CONFIG[0] = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (xfer_cnt == d0 && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    CONFIG[0] = 1'b0;
    repeat (3) @(negedge PCLK);
    chk({tag, "_xfer_done"}, xfer_cnt - d0, 1);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_cmd_left"}, exp_cmd.size(), 0);
    chk({tag, "_rx_left"}, exp_rx.size(), 0);
  endtask

  initial begin
    int d0, t0, r0, c0, a0, n;
    PRESETn = 1'b1;
    CONFIG  = '0;
    TIMEOUT = '0;
    bus.RX_FULL   = 1'b0;
    bus.CMD_READY = 1'b1;
    #3 PRESETn = 1'b0;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_xfer_done", XFER_DONE, 0);
    chk("rst_cmd_valid", bus.CMD_VALID, 0);
    chk("rst_rx_wdata", bus.RX_WDATA, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // write 2 bytes to 0x50
    tx_q.push_back(32'hFFFF_FFA5);
    tx_q.push_back(32'h0000_003C);
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'hA0));
    exp_cmd.push_back(mk(2'b01, 1'b0, 8'hA5));
    exp_cmd.push_back(mk(2'b01, 1'b0, 8'h3C));
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt; t0 = tx_pops;
    start_xfer(1'b0, 7'h50, 5'd2);
    chk("wr2_busy_running", BUSY, 1);
    wait_done("wr2", d0);
    chk("wr2_tx_pops", tx_pops - t0, 2);
    chk("wr2_error", ERROR, 0);

    // read 3 bytes from 0x21
    rd_q = '{8'h11, 8'h22, 8'h33};
    exp_rx = '{32'h11, 32'h22, 32'h33};
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'h43));
    exp_cmd.push_back(mk(2'b10, 1'b0, 8'h00));
    exp_cmd.push_back(mk(2'b10, 1'b0, 8'h00));
    exp_cmd.push_back(mk(2'b10, 1'b1, 8'h00));
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt; r0 = rx_pushes;
    start_xfer(1'b1, 7'h21, 5'd3);
    wait_done("rd3", d0);
    chk("rd3_rx_pushes", rx_pushes - r0, 3);
    chk("rd3_error", ERROR, 0);

    // address NACK: no data phase, straight to STOP
    nack_addr = 1'b1;
    tx_q.push_back(32'h99);
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'hA0));
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt; t0 = tx_pops;
    start_xfer(1'b0, 7'h50, 5'd1);
    wait_done("nack", d0);
    chk("nack_error", ERROR, 1);
    chk("nack_tx_pops", tx_pops - t0, 0);
    nack_addr = 1'b0;
    tx_q.delete();

    // timeout 5 with engine stalled in ADDR; the stall counter is 0 on
    // the first ADDR cycle, so the limit hits on the sixth stalled cycle
    TIMEOUT = 14'd5;
    bus.CMD_READY = 1'b0;
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt; a0 = addr_stall;
    start_xfer(1'b0, 7'h50, 5'd1);
    n = 0;
    while (!ERROR && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk("tmo_error", ERROR, 1);
    chk("tmo_stall_cycles", addr_stall - a0, 6);
    chk("tmo_stop_type", bus.CMD_TYPE, 2'b11);
    chk("tmo_stop_valid", bus.CMD_VALID, 1);
    bus.CMD_READY = 1'b1;
    wait_done("tmo", d0);
    chk("tmo_error_sticky", ERROR, 1);

    // timeout disabled: long stall is not an error
    TIMEOUT = 14'd0;
    bus.CMD_READY = 1'b0;
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'hA0));
    exp_cmd.push_back(mk(2'b01, 1'b0, 8'h77));
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt;
    start_xfer(1'b0, 7'h50, 5'd1);
    repeat (60) @(negedge PCLK);
    chk("notmo_error", ERROR, 0);
    chk("notmo_busy", BUSY, 1);
    tx_q.push_back(32'h77);
    bus.CMD_READY = 1'b1;
    wait_done("notmo", d0);
    chk("notmo_error_end", ERROR, 0);

    // read with RX FIFO full
    bus.RX_FULL = 1'b1;
    rd_q.push_back(8'h5A);
    exp_rx.push_back(32'h5A);
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'h43));
    exp_cmd.push_back(mk(2'b10, 1'b1, 8'h00));
    exp_cmd.push_back(mk(2'b11, 1'b0, 8'h00));
    d0 = xfer_cnt; r0 = rx_pushes; c0 = cmd_cnt;
    start_xfer(1'b1, 7'h21, 5'd1);
    n = 0;
    while (cmd_cnt - c0 < 2 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk("full_read_issued", cmd_cnt - c0, 2);
    repeat (12) @(negedge PCLK);
    chk("full_no_push", rx_pushes - r0, 0);
    chk("full_busy", BUSY, 1);
    bus.RX_FULL = 1'b0;
    wait_done("full", d0);
    chk("full_push", rx_pushes - r0, 1);

    // async reset in WAIT_WR with CONFIG[0] held high
    hold_wr = 1'b1;
    tx_q.push_back(32'h12);
    tx_q.push_back(32'h34);
    exp_cmd.push_back(mk(2'b00, 1'b0, 8'hA0));
    exp_cmd.push_back(mk(2'b01, 1'b0, 8'h12));
    c0 = cmd_cnt;
    start_xfer(1'b0, 7'h50, 5'd2);
    n = 0;
    while (cmd_cnt - c0 < 2 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk("mrst_write_issued", cmd_cnt - c0, 2);
    repeat (2) @(negedge PCLK);
    chk("mrst_busy_before", BUSY, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mrst_busy", BUSY, 0);
    chk("mrst_error", ERROR, 0);
    chk("mrst_xfer_done", XFER_DONE, 0);
    chk("mrst_cmd", {bus.CMD_VALID, bus.CMD_TYPE, bus.CMD_DATA,
                     bus.CMD_LAST}, 0);
    chk("mrst_strobes", {bus.TX_RD_EN, bus.RX_WR_EN}, 0);
    chk("mrst_rx_wdata", bus.RX_WDATA, 0);
    chk("mrst_cmd_left", exp_cmd.size(), 0);
    tx_q.delete();
    hold_wr = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    c0 = cmd_cnt;
    repeat (20) @(negedge PCLK);
    chk("mrst_no_restart_busy", BUSY, 0);
    chk("mrst_no_restart_cmds", cmd_cnt - c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
